// File: rtl/regbank_access_seq.sv
// rtl/regbank_access_seq.sv - command-to-access sequencer for the single-port register bank
//
// Accepts one command per cmd handshake (optional writeback, then up to two operand
// reads), issues each as a register-bank access fired by toggling rb_trigger_o, and
// presents the collected operands on the op handshake.
//
// Ports:
//   clk_i, rst_n_i            clock (posedge) and asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o command handshake; cmd_ready_o is high only in IDLE
//   cmd_wr_en_i, cmd_rd_i, cmd_wdata_i    writeback request
//   cmd_rn_en_i, cmd_rn_i     operand A read request
//   cmd_rm_en_i, cmd_rm_i     operand B read request
//   op_valid_o / op_ready_i   result handshake; op_a_o / op_b_o operand values
//   busy_o                    high whenever the sequencer is not IDLE
//   rb_addr_o, rb_wdata_o, rb_rdata_i, rb_trigger_o, rb_rw_o   register bank side
module regbank_access_seq #(
    parameter int SETTLE = 2,
    parameter int AW     = 4,
    parameter int DW     = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_wr_en_i,
    input  logic [AW-1:0] cmd_rd_i,
    input  logic [DW-1:0] cmd_wdata_i,
    input  logic          cmd_rn_en_i,
    input  logic [AW-1:0] cmd_rn_i,
    input  logic          cmd_rm_en_i,
    input  logic [AW-1:0] cmd_rm_i,
    output logic          op_valid_o,
    input  logic          op_ready_i,
    output logic [DW-1:0] op_a_o,
    output logic [DW-1:0] op_b_o,
    output logic          busy_o,
    output logic [AW-1:0] rb_addr_o,
    output logic [DW-1:0] rb_wdata_o,
    input  logic [DW-1:0] rb_rdata_i,
    output logic          rb_trigger_o,
    output logic          rb_rw_o
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_TRIG, S_WAIT, S_RESP} state_e;
    typedef enum logic [1:0] {K_NONE, K_WR, K_RDA, K_RDB} kind_e;

    state_e        state_q, state_d;
    kind_e         cur_q, cur_d;
    logic [2:0]    pend_q, pend_d;      // bit0 = WR, bit1 = RD_A, bit2 = RD_B
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] rbw_q, rbw_d;
    logic          trig_q, trig_d;
    logic          rw_q, rw_d;

    // Sources for the next access: live command inputs on the accept edge,
    // latched copies for later accesses.
    logic [2:0]    pend_s;
    logic [AW-1:0] rd_s, rn_s, rm_s;
    logic [DW-1:0] wdata_s;
    logic          load;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cur_q   <= K_NONE;
            pend_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            wdata_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            addr_q  <= '0;
            rbw_q   <= '0;
            trig_q  <= 1'b0;
            rw_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            wdata_q <= wdata_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            addr_q  <= addr_d;
            rbw_q   <= rbw_d;
            trig_q  <= trig_d;
            rw_q    <= rw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        wdata_d = wdata_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        addr_d  = addr_q;
        rbw_d   = rbw_q;
        trig_d  = trig_q;
        rw_d    = rw_q;
        pend_s  = pend_q;
        rd_s    = rd_q;
        rn_s    = rn_q;
        rm_s    = rm_q;
        wdata_s = wdata_q;
        load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    pend_s  = {cmd_rm_en_i, cmd_rn_en_i, cmd_wr_en_i};
                    rd_s    = cmd_rd_i;
                    rn_s    = cmd_rn_i;
                    rm_s    = cmd_rm_i;
                    wdata_s = cmd_wdata_i;
                    rd_d    = cmd_rd_i;
                    rn_d    = cmd_rn_i;
                    rm_d    = cmd_rm_i;
                    wdata_d = cmd_wdata_i;
                    pend_d  = pend_s;
                    op_a_d  = '0;
                    op_b_d  = '0;
                    if (pend_s == 3'b000) begin
                        // An empty command spends one final WAIT cycle with no
                        // access so completion still trails the accept by a cycle.
                        state_d = S_WAIT;
                        cur_d   = K_NONE;
                        cnt_d   = CNT_LAST;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_TRIG;
                trig_d  = ~trig_q;
            end
            S_TRIG: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    if (cur_q == K_RDA) op_a_d = rb_rdata_i;
                    if (cur_q == K_RDB) op_b_d = rb_rdata_i;
                    if (pend_q != 3'b000) load = 1'b1;
                    else                  state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (op_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Start the lowest-numbered pending access; the fixed WR, RD_A, RD_B order
        // is what lets a read of the writeback register see the new data.
        if (load) begin
            state_d = S_SETUP;
            if (pend_s[0]) begin
                addr_d = rd_s;
                rw_d   = 1'b0;
                rbw_d  = wdata_s;
                cur_d  = K_WR;
                pend_d = pend_s & 3'b110;
            end else if (pend_s[1]) begin
                addr_d = rn_s;
                rw_d   = 1'b1;
                cur_d  = K_RDA;
                pend_d = pend_s & 3'b100;
            end else begin
                addr_d = rm_s;
                rw_d   = 1'b1;
                cur_d  = K_RDB;
                pend_d = 3'b000;
            end
        end
    end

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign op_valid_o   = (state_q == S_RESP);
    assign op_a_o       = op_a_q;
    assign op_b_o       = op_b_q;
    assign rb_addr_o    = addr_q;
    assign rb_wdata_o   = rbw_q;
    assign rb_trigger_o = trig_q;
    assign rb_rw_o      = rw_q;

endmodule

// File: tb/tb_regbank_access_seq.sv
// tb/tb_regbank_access_seq.sv - self-checking bench for regbank_access_seq
module tb_regbank_access_seq;

    localparam int SETTLE = 2;
    localparam int AW     = 4;
    localparam int DW     = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_wr_en, cmd_rn_en, cmd_rm_en;
    logic [AW-1:0] cmd_rd, cmd_rn, cmd_rm;
    logic [DW-1:0] cmd_wdata;
    logic          op_valid, op_ready, busy;
    logic [DW-1:0] op_a, op_b;
    logic [AW-1:0] rb_addr;
    logic [DW-1:0] rb_wdata, rb_rdata;
    logic          rb_trigger, rb_rw;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    regbank_access_seq #(.SETTLE(SETTLE), .AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_wr_en_i(cmd_wr_en), .cmd_rd_i(cmd_rd), .cmd_wdata_i(cmd_wdata),
        .cmd_rn_en_i(cmd_rn_en), .cmd_rn_i(cmd_rn),
        .cmd_rm_en_i(cmd_rm_en), .cmd_rm_i(cmd_rm),
        .op_valid_o(op_valid), .op_ready_i(op_ready),
        .op_a_o(op_a), .op_b_o(op_b), .busy_o(busy),
        .rb_addr_o(rb_addr), .rb_wdata_o(rb_wdata), .rb_rdata_i(rb_rdata),
        .rb_trigger_o(rb_trigger), .rb_rw_o(rb_rw)
    );

    // Register bank: acts on every trigger edge, logs each access.
    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    logic [DW-1:0] bank_mem [16];
    logic [DW-1:0] ref_mem  [16];
    acc_t          acc_log  [$];
    int            toggles;
    logic          trig_prev = 1'b0;

    always @(negedge clk) begin
        if (rb_trigger !== trig_prev) begin
            toggles++;
            acc_log.push_back({rb_rw, rb_addr, rb_wdata});
            if (rb_rw) rb_rdata = bank_mem[rb_addr];
            else       bank_mem[rb_addr] = rb_wdata;
        end
        trig_prev = rb_trigger;
    end

    function automatic int exp_lat(input int n);
        return (n == 0) ? 1 : n * (2 + SETTLE);
    endfunction

    task automatic run_cmd(input logic wr, input logic [AW-1:0] rd, input logic [DW-1:0] wd,
                           input logic ra, input logic [AW-1:0] rn,
                           input logic rb, input logic [AW-1:0] rm, output int lat);
        int w;
        @(negedge clk);
        acc_log.delete();
        toggles   = 0;
        cmd_wr_en = wr; cmd_rd = rd; cmd_wdata = wd;
        cmd_rn_en = ra; cmd_rn = rn; cmd_rm_en = rb; cmd_rm = rm;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wr_en = 1'($urandom); cmd_rd = AW'($urandom); cmd_wdata = $urandom;
        cmd_rn_en = 1'($urandom); cmd_rn = AW'($urandom);
        cmd_rm_en = 1'($urandom); cmd_rm = AW'($urandom);
        lat = 0;
        while (!op_valid && lat < 200) begin @(negedge clk); lat++; end
        if (!op_valid) lat = -1;
    endtask

    task automatic finish_cmd();
        op_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        nvec++; if (op_valid !== 1'b0) begin nerr++; $display("FAIL reset_op_valid got %b want 0", op_valid); end
        nvec++; if (rb_trigger !== 1'b0 || rb_rw !== 1'b1) begin nerr++; $display("FAIL reset_trig_rw got %b/%b want 0/1", rb_trigger, rb_rw); end
        nvec++; if (rb_addr !== '0 || rb_wdata !== '0 || busy !== 1'b0) begin nerr++; $display("FAIL reset_addr_wdata_busy got %h/%h/%b want 0/0/0", rb_addr, rb_wdata, busy); end
        nvec++; if (op_a !== '0 || op_b !== '0) begin nerr++; $display("FAIL reset_ops got %h/%h want 0/0", op_a, op_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_two_reads();
        int lat;
        bank_mem[1] = 32'd0; bank_mem[2] = 32'd1;
        ref_mem[1]  = 32'd0; ref_mem[2]  = 32'd1;
        run_cmd(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 1'b1, 4'd1, lat);
        nvec++; if (lat !== 8) begin nerr++; $display("FAIL t2_latency got %0d want 8", lat); end
        nvec++; if (op_a !== 32'd1 || op_b !== 32'd0) begin nerr++; $display("FAIL t2_ops got %h/%h want 1/0", op_a, op_b); end
        nvec++; if (toggles !== 2) begin nerr++; $display("FAIL t2_toggles got %0d want 2", toggles); end
        nvec++;
        if (acc_log.size() != 2 || acc_log[0].rw !== 1'b1 || acc_log[1].rw !== 1'b1 ||
            acc_log[0].addr !== 4'd2 || acc_log[1].addr !== 4'd1) begin
            nerr++; $display("FAIL t2_access_order got %0d accesses want rd@2 then rd@1", acc_log.size());
        end
        finish_cmd();
    endtask

    task automatic test_write_then_read();
        int lat;
        run_cmd(1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 4'd5, 1'b0, 4'd0, lat);
        ref_mem[5] = 32'hDEADBEEF;
        nvec++; if (lat !== 8) begin nerr++; $display("FAIL t3_latency got %0d want 8", lat); end
        nvec++; if (op_a !== 32'hDEADBEEF || op_b !== 32'd0) begin nerr++; $display("FAIL t3_ops got %h/%h want deadbeef/0", op_a, op_b); end
        nvec++;
        if (acc_log.size() != 2 || acc_log[0].rw !== 1'b0 || acc_log[0].addr !== 4'd5 ||
            acc_log[0].wdata !== 32'hDEADBEEF || acc_log[1].rw !== 1'b1 || acc_log[1].addr !== 4'd5) begin
            nerr++; $display("FAIL t3_access_order got %0d accesses want wr@5 then rd@5", acc_log.size());
        end
        finish_cmd();
    endtask

    task automatic test_op_ready_hold();
        int lat;
        bank_mem[1] = 32'd0; bank_mem[2] = 32'd1;
        run_cmd(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 1'b1, 4'd1, lat);
        nvec++; if (lat !== 8) begin nerr++; $display("FAIL t4_latency got %0d want 8", lat); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++;
            if (op_valid !== 1'b1 || op_a !== 32'd1 || op_b !== 32'd0 || cmd_ready !== 1'b0 || toggles !== 2) begin
                nerr++;
                $display("FAIL t4_hold cycle %0d got v=%b a=%h b=%h rdy=%b tog=%0d want 1/1/0/0/2",
                         i, op_valid, op_a, op_b, cmd_ready, toggles);
            end
        end
        finish_cmd();
        nvec++; if (cmd_ready !== 1'b1 || op_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL t4_idle_after got rdy=%b v=%b busy=%b want 1/0/0", cmd_ready, op_valid, busy); end
    endtask

    task automatic test_reset_mid_access();
        int lat;
        bank_mem[1] = 32'd0; bank_mem[2] = 32'd1;
        test_reset();
        @(negedge clk);
        cmd_wr_en = 1'b0; cmd_rn_en = 1'b1; cmd_rn = 4'd2; cmd_rm_en = 1'b1; cmd_rm = 4'd1;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nvec++; if (rb_trigger !== 1'b1 || busy !== 1'b1) begin nerr++; $display("FAIL t5_in_wait got trig=%b busy=%b want 1/1", rb_trigger, busy); end
        rst_n = 1'b0;
        #1;
        nvec++;
        if (rb_trigger !== 1'b0 || rb_rw !== 1'b1 || rb_addr !== '0 || rb_wdata !== '0 ||
            cmd_ready !== 1'b1 || op_valid !== 1'b0 || busy !== 1'b0 || op_a !== '0 || op_b !== '0) begin
            nerr++;
            $display("FAIL t5_async_reset got trig=%b rw=%b addr=%h rdy=%b v=%b busy=%b want 0/1/0/1/0/0",
                     rb_trigger, rb_rw, rb_addr, cmd_ready, op_valid, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cmd(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 1'b1, 4'd1, lat);
        nvec++; if (lat !== 8 || op_a !== 32'd1 || op_b !== 32'd0) begin nerr++; $display("FAIL t5_rerun got lat=%0d a=%h b=%h want 8/1/0", lat, op_a, op_b); end
        finish_cmd();
    endtask

    task automatic test_empty();
        int lat;
        run_cmd(1'b0, 4'd3, 32'h1234, 1'b0, 4'd3, 1'b0, 4'd4, lat);
        nvec++; if (lat !== 1) begin nerr++; $display("FAIL t6_latency got %0d want 1", lat); end
        nvec++; if (op_a !== '0 || op_b !== '0 || toggles !== 0) begin nerr++; $display("FAIL t6_result got a=%h b=%h tog=%0d want 0/0/0", op_a, op_b, toggles); end
        finish_cmd();
    endtask

    task automatic test_random();
        int lat, n, hold;
        logic          wr, ra, rb;
        logic [AW-1:0] rd, rn, rm;
        logic [DW-1:0] wd, ea, eb;
        acc_t          exp_q [$];
        for (int t = 0; t < 30; t++) begin
            wr = 1'($urandom); ra = 1'($urandom); rb = 1'($urandom);
            rd = AW'($urandom); rm = AW'($urandom); wd = $urandom;
            rn = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom);
            // Reference: writeback lands first, then reads see the updated bank.
            exp_q.delete();
            if (wr) begin ref_mem[rd] = wd; exp_q.push_back({1'b0, rd, wd}); end
            ea = ra ? ref_mem[rn] : '0;
            eb = rb ? ref_mem[rm] : '0;
            if (ra) exp_q.push_back({1'b1, rn, {DW{1'b0}}});
            if (rb) exp_q.push_back({1'b1, rm, {DW{1'b0}}});
            n = exp_q.size();
            run_cmd(wr, rd, wd, ra, rn, rb, rm, lat);
            nvec++; if (lat !== exp_lat(n)) begin nerr++; $display("FAIL rnd%0d_latency got %0d want %0d", t, lat, exp_lat(n)); end
            nvec++; if (op_a !== ea || op_b !== eb) begin nerr++; $display("FAIL rnd%0d_ops got %h/%h want %h/%h", t, op_a, op_b, ea, eb); end
            nvec++; if (toggles !== n) begin nerr++; $display("FAIL rnd%0d_toggles got %0d want %0d", t, toggles, n); end
            nvec++;
            if (acc_log.size() != n) begin
                nerr++; $display("FAIL rnd%0d_access_count got %0d want %0d", t, acc_log.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    if (acc_log[i].rw !== exp_q[i].rw || acc_log[i].addr !== exp_q[i].addr ||
                        (!exp_q[i].rw && acc_log[i].wdata !== exp_q[i].wdata)) begin
                        nerr++;
                        $display("FAIL rnd%0d_access%0d got rw=%b addr=%h want rw=%b addr=%h",
                                 t, i, acc_log[i].rw, acc_log[i].addr, exp_q[i].rw, exp_q[i].addr);
                        break;
                    end
                end
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                nvec++; if (op_valid !== 1'b1 || op_a !== ea || op_b !== eb) begin nerr++; $display("FAIL rnd%0d_hold got v=%b want 1", t, op_valid); end
            end
            finish_cmd();
        end
        nvec++;
        for (int i = 0; i < 16; i++) begin
            if (bank_mem[i] !== ref_mem[i]) begin
                nerr++; $display("FAIL bank_contents addr %0d got %h want %h", i, bank_mem[i], ref_mem[i]);
                break;
            end
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_wr_en = 1'b0; cmd_rn_en = 1'b0; cmd_rm_en = 1'b0;
        cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_wdata = '0;
        op_ready = 1'b0; rb_rdata = '0; toggles = 0;
        for (int i = 0; i < 16; i++) begin
            bank_mem[i] = $urandom;
            ref_mem[i]  = bank_mem[i];
        end
        test_reset();
        test_two_reads();
        test_write_then_read();
        test_op_ready_hold();
        test_reset_mid_access();
        test_empty();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
